// File: rtl/load_store_unit.sv
// load_store_unit: big-endian byte/half/word load-store engine; sub-word stores run as read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module load_store_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Req,
   input  logic        Wr,
   input  logic [2:0]  Size,
   input  logic [31:0] Addr,
   input  logic [31:0] Store_data,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic [31:0] Load_data,
   output logic [31:0] Mem_addr,
   output logic [31:0] Mem_wdata,
   output logic        Mem_read,
   output logic        Mem_write,
   input  logic [31:0] Mem_rdata
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
   state_t state, state_nxt;
   logic [3:0] cnt;
   logic wr_q;
   logic [2:0] size_q;
   logic [1:0] off_q;
   logic [15:0] sdata_q;
   logic accept, illegal, misalign, err_req, wait_last, sgn;
   logic [4:0] sh;
   logic [15:0] lane;
   logic [31:0] mask, ins, merged, ext;
   assign accept = state == IDLE && Req;
   assign illegal = Size == 3'b010 || Size[2:1] == 2'b11 || (Wr && Size[2]);
`ifdef LSU_ALIGN_CHECK_EN
   assign misalign = (Size[1:0] == 2'b01 && Addr[0]) || (Size[1:0] == 2'b11 && Addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   assign err_req = illegal || misalign;
   assign wait_last = cnt == 4'(MEM_LAT - 1);
   // Shift that brings the addressed lane down to bit 0 (big-endian: offset 0 is the top byte).
   assign sh = size_q[0] ? {~off_q[1], 4'b0000} : {~off_q, 3'b000};
   assign lane = 16'(Mem_rdata >> sh);
   assign sgn = ~size_q[2];
   assign ext = size_q[1] ? Mem_rdata :
                size_q[0] ? {{16{sgn & lane[15]}}, lane} :
                            {{24{sgn & lane[7]}}, lane[7:0]};
   assign mask = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
   assign ins = (size_q[0] ? {16'h0, sdata_q} : {24'h0, sdata_q[7:0]}) << sh;
   assign merged = (Mem_rdata & ~mask) | ins;
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !Req ? IDLE : err_req ? DONE : (Wr && Size == 3'b011) ? WRITE : READ;
         READ:    state_nxt = WAIT;
         WAIT:    state_nxt = !wait_last ? WAIT : wr_q ? WRITE : DONE;
         WRITE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         Load_data <= '0;
         Mem_addr  <= '0;
         Mem_wdata <= '0;
         Mem_read  <= 1'b0;
         Mem_write <= 1'b0;
         cnt       <= '0;
         wr_q      <= 1'b0;
         size_q    <= '0;
         off_q     <= '0;
         sdata_q   <= '0;
      end else begin
         Busy      <= state_nxt != IDLE;
         Done      <= state_nxt == DONE;
         Mem_read  <= state_nxt == READ;
         Mem_write <= state_nxt == WRITE;
         Err       <= accept && err_req;
         if (accept) begin
            Mem_addr  <= {Addr[31:2], 2'b00};
            Mem_wdata <= Store_data;
            wr_q      <= Wr;
            size_q    <= Size;
            off_q     <= Addr[1:0];
            sdata_q   <= Store_data[15:0];
         end
         if (state == WAIT) begin
            cnt <= wait_last ? 4'd0 : cnt + 4'd1;
            if (wait_last && wr_q) Mem_wdata <= merged;
            if (wait_last && !wr_q) Load_data <= ext;
         end
      end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench; instance 0 runs MEM_LAT=1, instance 1 MEM_LAT=3.
module tb_load_store_unit;
  typedef struct {
    int          rd;
    int          wr;
    logic [31:0] wd;
    logic [31:0] wa;
    int          done;
    logic        err;
    logic [31:0] ld;
  } exp_t;
  logic clk_i = 1'b0;
  logic Clk;
  logic Rst_n = 1'b0;
  logic [1:0] req = '0, wr = '0;
  logic [1:0] busy, done, err, mem_read, mem_write;
  logic [1:0][2:0] size = '0;
  logic [1:0][31:0] addr = '0, sdata = '0;
  logic [1:0][31:0] load_data, mem_addr, mem_wdata;
  exp_t exp_q[$];
  int n_vec = 0, n_mis = 0;
  assign Clk = clk_i;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int LAT = g ? 3 : 1;
    logic [31:0] mem [16] = '{4: 32'h8899AABB, default: 32'h0};
    logic [31:0] rdata = 32'hDEADBEEF;
    logic [31:0] pa = '0;
    int cd = 0;
    load_store_unit #(.MEM_LAT(LAT)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Req(req[g]), .Wr(wr[g]), .Size(size[g]),
      .Addr(addr[g]), .Store_data(sdata[g]), .Busy(busy[g]), .Done(done[g]),
      .Err(err[g]), .Load_data(load_data[g]), .Mem_addr(mem_addr[g]),
      .Mem_wdata(mem_wdata[g]), .Mem_read(mem_read[g]), .Mem_write(mem_write[g]),
      .Mem_rdata(rdata)
    );
    always @(posedge Clk) begin
      rdata <= 32'hDEADBEEF;
      if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) rdata <= mem[pa[5:2]];
      end
      if (mem_read[g]) begin
        if (LAT == 1) rdata <= mem[mem_addr[g][5:2]];
        else begin
          cd <= LAT - 1;
          pa <= mem_addr[g];
        end
      end
      if (mem_write[g]) mem[mem_addr[g][5:2]] <= mem_wdata[g];
    end
  end
  function automatic exp_t mk(int rd, int wrc, logic [31:0] wd, logic [31:0] wa, int dc, logic e, logic [31:0] ld);
    exp_t x;
    x.rd = rd; x.wr = wrc; x.wd = wd; x.wa = wa; x.done = dc; x.err = e; x.ld = ld;
    return x;
  endfunction
  task automatic txn(input int g, input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] sd, input exp_t e);
    exp_t x;
    int cyc, rd_c, wr_c;
    logic [31:0] wd, wa;
    logic seen;
    exp_q.push_back(e);
    @(negedge Clk);
    req[g] = 1'b1; wr[g] = w; size[g] = sz; addr[g] = a; sdata[g] = sd;
    cyc = 0; rd_c = -1; wr_c = -1; wd = '0; wa = '0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
      req[g] = 1'b0;
      chk("strobe_excl", mem_read[g] & mem_write[g], 1'b0);
      if (mem_read[g] && rd_c < 0) rd_c = cyc;
      if (mem_write[g]) begin
        wr_c = cyc; wd = mem_wdata[g]; wa = mem_addr[g];
      end
      if (done[g]) begin
        seen = 1'b1;
        x = exp_q.pop_front();
        chk("done_cycle", cyc, x.done);
        chk("err", err[g], x.err);
        chk("load_data", load_data[g], x.ld);
        chk("read_cycle", rd_c, x.rd);
        chk("write_cycle", wr_c, x.wr);
        chk("busy_in_done", busy[g], 1'b1);
        if (x.wr >= 0) begin
          chk("mem_wdata", wd, x.wd);
          chk("mem_addr", wa, x.wa);
        end
      end
    end
    chk("done_seen", seen, 1'b1);
    if (!seen) exp_q.delete();
    @(posedge Clk); #1;
    chk("idle_after_done", busy[1'(g)], 1'b0);
  endtask
  initial begin
    logic [31:0] ld0;
    exp_t x;
    int cyc, reads;
    logic wrote, dseen;
    ld0 = '0;
    repeat (3) @(posedge Clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", busy[g], 1'b0);
      chk("rst_done", done[g], 1'b0);
      chk("rst_err", err[g], 1'b0);
      chk("rst_load_data", load_data[g], 32'h0);
      chk("rst_mem_addr", mem_addr[g], 32'h0);
      chk("rst_mem_wdata", mem_wdata[g], 32'h0);
      chk("rst_mem_read", mem_read[g], 1'b0);
      chk("rst_mem_write", mem_write[g], 1'b0);
    end
    @(negedge Clk); Rst_n = 1'b1;
    txn(0, 1'b0, 3'b000, 32'h11, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, 32'hFFFFFF99));
    txn(0, 1'b0, 3'b100, 32'h11, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, 32'h00000099));
    txn(0, 1'b0, 3'b101, 32'h12, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, 32'h0000AABB));
    txn(0, 1'b0, 3'b001, 32'h10, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, 32'hFFFF8899));
    txn(0, 1'b0, 3'b011, 32'h10, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, 32'h8899AABB));
    @(negedge Clk);
    req[0] = 1'b1; wr[0] = 1'b1; size[0] = 3'b000; addr[0] = 32'h10; sdata[0] = 32'h77;
    @(posedge Clk); #1;
    req[0] = 1'b0;
    chk("rmw_read", mem_read[0], 1'b1);
    @(posedge Clk); #1;
    chk("rmw_wait_busy", busy[0], 1'b1);
    Rst_n = 1'b0;
    #1;
    chk("arst_busy", busy[0], 1'b0);
    chk("arst_done", done[0], 1'b0);
    chk("arst_err", err[0], 1'b0);
    chk("arst_load_data", load_data[0], 32'h0);
    chk("arst_mem_addr", mem_addr[0], 32'h0);
    chk("arst_mem_wdata", mem_wdata[0], 32'h0);
    chk("arst_mem_read", mem_read[0], 1'b0);
    chk("arst_mem_write", mem_write[0], 1'b0);
    ld0 = '0;
    @(negedge Clk); Rst_n = 1'b1;
    wrote = 1'b0; dseen = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
      wrote |= mem_write[0];
      dseen |= done[0];
    end
    chk("arst_no_write", wrote, 1'b0);
    chk("arst_no_done", dseen, 1'b0);
    chk("arst_mem_kept", gm[0].mem[4], 32'h8899AABB);
    txn(0, 1'b1, 3'b001, 32'h12, 32'h00001234, mk(1, 3, 32'h88991234, 32'h10, 4, 1'b0, ld0));
    txn(0, 1'b1, 3'b000, 32'h13, 32'hFFFFFF55, mk(1, 3, 32'h88991255, 32'h10, 4, 1'b0, ld0));
    txn(0, 1'b1, 3'b000, 32'h10, 32'h000000C3, mk(1, 3, 32'hC3991255, 32'h10, 4, 1'b0, ld0));
    ld0 = 32'hC3991255;
    txn(0, 1'b0, 3'b011, 32'h10, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, ld0));
    txn(0, 1'b1, 3'b011, 32'h04, 32'h0000000A, mk(-1, 1, 32'h0000000A, 32'h04, 2, 1'b0, ld0));
    ld0 = 32'h0000000A;
    txn(0, 1'b0, 3'b011, 32'h04, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, ld0));
`ifdef LSU_ALIGN_CHECK_EN
    txn(0, 1'b0, 3'b011, 32'h06, 32'h0, mk(-1, -1, 0, 0, 1, 1'b1, ld0));
    txn(0, 1'b0, 3'b001, 32'h11, 32'h0, mk(-1, -1, 0, 0, 1, 1'b1, ld0));
`else
    txn(0, 1'b0, 3'b011, 32'h06, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, ld0));
    ld0 = 32'hFFFFC399;
    txn(0, 1'b0, 3'b001, 32'h11, 32'h0, mk(1, -1, 0, 0, 3, 1'b0, ld0));
`endif
    txn(0, 1'b1, 3'b100, 32'h10, 32'h0, mk(-1, -1, 0, 0, 1, 1'b1, ld0));
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, mk(-1, -1, 0, 0, 1, 1'b1, ld0));
    txn(0, 1'b0, 3'b111, 32'h10, 32'h0, mk(-1, -1, 0, 0, 1, 1'b1, ld0));
    chk("mem_after_stores", gm[0].mem[4], 32'hC3991255);
    exp_q.push_back(mk(1, -1, 0, 0, 5, 1'b0, 32'h8899AABB));
    exp_q.push_back(mk(7, -1, 0, 0, 11, 1'b0, 32'h8899AABB));
    @(negedge Clk);
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 3'b011; addr[1] = 32'h10;
    cyc = 0; reads = 0;
    while (cyc < 16) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 10) req[1] = 1'b0;
      chk("held_strobe_excl", mem_read[1] & mem_write[1], 1'b0);
      if (mem_read[1]) begin
        reads++;
        x = exp_q[0];
        chk("held_read_cycle", cyc, x.rd);
      end
      if (done[1]) begin
        x = exp_q.pop_front();
        chk("held_done_cycle", cyc, x.done);
        chk("held_load_data", load_data[1], x.ld);
        chk("held_err", err[1], 1'b0);
      end
    end
    chk("held_read_count", reads, 2);
    chk("held_all_done", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
